// File: rtl/hash_window_scroller_if.sv
// Digest-in / window-out bundle between the SHA-256 core, the scroller and the segment driver.
// The master drives the digest and controls, and the slave (the scroller) drives the display outputs.
interface hash_window_scroller_if;
   logic [255:0] hash_in;
   logic         hash_valid;
   logic         auto_en;
   logic         step;
   logic [15:0]  digits;
   logic [3:0]   index;
   logic         loaded;
   logic         wrap;

   modport master (
      output hash_in, hash_valid, auto_en, step,
      input  digits, index, loaded, wrap
   );

   modport slave (
      input  hash_in, hash_valid, auto_en, step,
      output digits, index, loaded, wrap
   );
endinterface

// File: rtl/hash_window_scroller.sv
// Holds a 256-bit digest and shows it as sixteen 16-bit windows, MS window first.
// Windows advance on a prescaled tick (auto mode) or on a debounced button press.
module hash_window_scroller #(
   parameter int PRESCALE = 62500000,
   parameter int DEBOUNCE = 1250000
) (
   input logic                   clk,
   input logic                   rst,
   hash_window_scroller_if.slave bus
);
   localparam int PW = $clog2(PRESCALE);
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   typedef enum logic {S_IDLE, S_SHOW} state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [255:0]   r_hash;
   logic [15:0]    r_digits;
   logic [3:0]     r_index;
   logic           r_wrap;
   logic [PW-1:0]  r_pre;
   logic [1:0]     r_sync;
   logic [DW-1:0]  r_db_cnt;
   logic           r_db_lvl;
   logic           r_db_prev;

   logic           w_press;
   logic           w_tick;
   logic           w_load;
   logic           w_adv;
   logic [3:0]     w_idx_next;
   logic [7:0]     w_base;

   assign w_press    = r_db_lvl & ~r_db_prev;
   assign w_tick     = (r_state == S_SHOW) && bus.auto_en && (r_pre == PW'(PRESCALE - 1));
   assign w_idx_next = r_index - 4'd1;
   assign w_base     = {w_idx_next, 4'b0000};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Load outranks advance, and a tick coinciding with a press is a single advance.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_adv        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.hash_valid) begin
               w_load       = 1'b1;
               w_state_next = S_SHOW;
            end
         end
         S_SHOW: begin
            if (bus.hash_valid)         w_load = 1'b1;
            else if (w_tick || w_press) w_adv  = 1'b1;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hash    <= '0;
         r_digits  <= '0;
         r_index   <= '0;
         r_wrap    <= 1'b0;
         r_pre     <= '0;
         r_sync    <= '0;
         r_db_cnt  <= '0;
         r_db_lvl  <= 1'b0;
         r_db_prev <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], bus.step};
         r_db_prev <= r_db_lvl;
         // The level flips only after DEBOUNCE straight cycles that disagree with it.
         if (r_sync[1] == r_db_lvl) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DW'(DEBOUNCE - 1)) begin
            r_db_lvl <= r_sync[1];
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end

         r_wrap <= 1'b0;
         if (w_load) begin
            r_hash   <= bus.hash_in;
            r_index  <= 4'hF;
            r_digits <= bus.hash_in[255:240];
            r_pre    <= '0;
         end else if (w_adv) begin
            r_index  <= w_idx_next;
            r_digits <= r_hash[w_base +: 16];
            r_pre    <= '0;
            r_wrap   <= (r_index == 4'h0);
         end else if (r_state == S_SHOW && bus.auto_en) begin
            r_pre    <= r_pre + 1'b1;
         end else begin
            r_pre    <= '0;
         end
      end
   end

   assign bus.digits = r_digits;
   assign bus.index  = r_index;
   assign bus.loaded = (r_state == S_SHOW);
   assign bus.wrap   = r_wrap;
endmodule

// File: tb/tb_hash_window_scroller.sv
// Directed and random bench for hash_window_scroller.
// A behavioural model is compared against the outputs every cycle.
module tb_hash_window_scroller;
   localparam int PRE = 4;
   localparam int DEB = 3;
   localparam logic [255:0] HD =
      256'hd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hash_window_scroller_if bus();

   hash_window_scroller #(.PRESCALE(PRE), .DEBOUNCE(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   // Model state: the digest, the window number, and the button history.
   logic         m_loaded;
   logic [255:0] m_hash;
   logic [3:0]   m_idx;
   logic         m_wrap;
   int           m_ph;
   logic         m_lvl, m_pend;
   logic         st0, st1;
   logic         sh [DEB];

   function automatic logic [15:0] model_digits();
      return m_loaded ? m_hash[int'(m_idx)*16 +: 16] : 16'h0000;
   endfunction

   task automatic model_edge();
      logic synced, allsame, newlvl, press, tick;
      if (rst) begin
         m_loaded = 0; m_hash = '0; m_idx = 0; m_wrap = 0; m_ph = 0;
         m_lvl = 0; m_pend = 0; st0 = 0; st1 = 0;
         for (int i = 0; i < DEB; i++) sh[i] = 0;
      end else begin
         synced = st1; st1 = st0; st0 = bus.step;
         for (int i = DEB - 1; i > 0; i--) sh[i] = sh[i-1];
         sh[0] = synced;
         allsame = 1;
         for (int i = 0; i < DEB; i++) if (sh[i] != sh[0]) allsame = 0;
         press  = m_pend;
         newlvl = allsame ? sh[0] : m_lvl;
         m_pend = newlvl & ~m_lvl;
         m_lvl  = newlvl;
         m_wrap = 0;
         if (bus.hash_valid) begin
            m_hash = bus.hash_in; m_idx = 4'hF; m_loaded = 1; m_ph = 0;
         end else if (m_loaded) begin
            tick = 0;
            if (bus.auto_en) begin
               m_ph++;
               if (m_ph == PRE) tick = 1;
            end else begin
               m_ph = 0;
            end
            if (tick || press) begin
               m_wrap = (m_idx == 4'h0);
               m_idx  = m_idx - 4'd1;
               m_ph   = 0;
            end
         end
      end
   endtask

   task automatic compare();
      logic [15:0] ed;
      ed = model_digits();
      n_checks++;
      if (bus.digits !== ed || bus.index !== m_idx || bus.loaded !== m_loaded || bus.wrap !== m_wrap) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL cmp cycle=%0d got d=%h i=%0d l=%b w=%b want d=%h i=%0d l=%b w=%b",
                     cycle, bus.digits, bus.index, bus.loaded, bus.wrap, ed, m_idx, m_loaded, m_wrap);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
      cycle++;
   endtask

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   int wraps;
   int lat;

   initial begin
      bus.hash_in = '0; bus.hash_valid = 0; bus.auto_en = 1; bus.step = 0;
      rst = 1;
      cyc(); cyc();
      rst = 0;
      cyc();
      lit("rst_digits", bus.digits, 16'h0000);
      lit("rst_index",  bus.index,  4'h0);
      lit("rst_loaded", bus.loaded, 1'b0);
      lit("rst_wrap",   bus.wrap,   1'b0);

      // Idle with auto on and the button bouncing slowly enough to be accepted.
      wraps = 0;
      for (int i = 0; i < 20; i++) begin
         bus.step = ((i / 5) % 2) == 1;
         cyc();
         if (bus.wrap) wraps++;
      end
      lit("idle_loaded", bus.loaded, 1'b0);
      lit("idle_digits", bus.digits, 16'h0000);
      lit("idle_wrap",   wraps, 0);

      bus.step = 0; bus.auto_en = 0;
      for (int i = 0; i < 8; i++) cyc();
      bus.hash_in = HD; bus.hash_valid = 1;
      cyc();
      bus.hash_valid = 0;
      lit("load_index",  bus.index,  4'hF);
      lit("load_digits", bus.digits, 16'hd0e8);
      lit("load_loaded", bus.loaded, 1'b1);
      lit("model_pin",   model_digits(), 16'hd0e8);
      for (int i = 0; i < 50; i++) cyc();
      lit("hold_digits", bus.digits, 16'hd0e8);

      // Full auto lap: 16 advances, one wrap on return to window 15.
      bus.auto_en = 1; wraps = 0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         if (bus.wrap) wraps++;
         if (i == 2)  lit("auto_pre",  bus.digits, 16'hd0e8);
         if (i == 3)  lit("auto_w14",  bus.digits, 16'hb8f1);
         if (i == 7)  lit("auto_w13",  bus.digits, 16'h1c98);
         if (i == 59) lit("auto_w0",   bus.digits, 16'h6271);
      end
      lit("wrap_once", wraps, 1);
      lit("auto_back", bus.digits, 16'hd0e8);

      // Manual stepping: short press rejected, long press gives one advance.
      bus.auto_en = 0;
      bus.step = 1; cyc(); cyc();
      bus.step = 0;
      for (int i = 0; i < 10; i++) cyc();
      lit("short_press", bus.index, 4'hF);
      bus.step = 1; lat = 0;
      while (bus.index == 4'hF && lat < 20) begin
         cyc();
         lat++;
      end
      lit("step_lat",    lat, 6);
      lit("step_digits", bus.digits, 16'hb8f1);
      for (int i = lat; i < 10; i++) cyc();
      bus.step = 0;
      for (int i = 0; i < 10; i++) cyc();
      lit("release", bus.index, 4'hE);

      // Reload coinciding with a tick at window 3.
      bus.auto_en = 1;
      for (int i = 0; i < 47; i++) cyc();
      lit("pre_reload_idx", bus.index, 4'h3);
      bus.hash_in = ~HD; bus.hash_valid = 1;
      cyc();
      bus.hash_valid = 0;
      lit("reload_idx",    bus.index,  4'hF);
      lit("reload_digits", bus.digits, 16'h2f17);
      lit("reload_wrap",   bus.wrap,   1'b0);

      // Mid-scroll reset then restart.
      for (int i = 0; i < 10; i++) cyc();
      rst = 1; cyc(); rst = 0;
      lit("mrst_digits", bus.digits, 16'h0000);
      lit("mrst_index",  bus.index,  4'h0);
      lit("mrst_loaded", bus.loaded, 1'b0);
      lit("mrst_wrap",   bus.wrap,   1'b0);
      bus.hash_in = HD; bus.hash_valid = 1;
      cyc();
      bus.hash_valid = 0;
      lit("restart_idx",    bus.index,  4'hF);
      lit("restart_digits", bus.digits, 16'hd0e8);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0)  bus.step = ~bus.step;
         if ($urandom_range(0, 40) == 0) bus.auto_en = ~bus.auto_en;
         bus.hash_valid = ($urandom_range(0, 60) == 0);
         if (bus.hash_valid)
            for (int k = 0; k < 8; k++) bus.hash_in[k*32 +: 32] = $urandom();
         rst = ($urandom_range(0, 400) == 0);
         cyc();
      end
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
